// File: rtl/fifo_access_arbiter.sv
// rtl/fifo_access_arbiter.sv - round-robin owner of one FIFO's control pins for two producers, one consumer and a flush
module fifo_access_arbiter #(
    parameter int MEM_SIZE   = 10,
    parameter int FILL_LIMIT = (1 << MEM_SIZE) - 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_req0,
    input  logic [7:0]          wr_data0,
    output logic                wr_ack0,
    input  logic                wr_req1,
    input  logic [7:0]          wr_data1,
    output logic                wr_ack1,
    input  logic                rd_req,
    output logic [7:0]          rd_data,
    output logic                rd_valid,
    input  logic                flush,
    output logic                flush_busy,
    output logic                fifo_we,
    output logic                fifo_re,
    output logic [7:0]          fifo_dataIn,
    input  logic [7:0]          fifo_dataOut,
    input  logic [MEM_SIZE-1:0] fifo_count,
    input  logic                fifo_isEmpty
);

    localparam logic [MEM_SIZE-1:0] LIMIT = MEM_SIZE'(FILL_LIMIT);

    typedef enum logic [1:0] {IDLE, WRITE, READ, FLUSH} state_t;
    typedef enum logic [1:0] {SRC_RD, SRC_W0, SRC_W1, SRC_NONE} src_t;

    state_t      state, state_n;
    src_t        rr_ptr, rr_n, grant;
    logic        flush_pend, pend_n;
    logic        we_n, re_n, ack0_n, ack1_n, rdv_n, busy_n;
    logic [7:0]  din_n, rdd_n;
    logic [2:0]  elig;

    // Fixed rotation RD -> W0 -> W1, starting the search at the pointer.
    function automatic src_t pick(input src_t start, input logic [2:0] e);
        src_t g;
        g = SRC_NONE;
        case (start)
            SRC_RD: begin
                if (e[0])      g = SRC_RD;
                else if (e[1]) g = SRC_W0;
                else if (e[2]) g = SRC_W1;
            end
            SRC_W0: begin
                if (e[1])      g = SRC_W0;
                else if (e[2]) g = SRC_W1;
                else if (e[0]) g = SRC_RD;
            end
            default: begin
                if (e[2])      g = SRC_W1;
                else if (e[0]) g = SRC_RD;
                else if (e[1]) g = SRC_W0;
            end
        endcase
        return g;
    endfunction

    always_comb begin
        elig[0] = rd_req && !fifo_isEmpty;
        elig[1] = wr_req0 && (fifo_count < LIMIT);
        elig[2] = wr_req1 && (fifo_count < LIMIT);
        grant   = pick(rr_ptr, elig);
    end

    always_comb begin
        state_n = state;
        rr_n    = rr_ptr;
        pend_n  = flush_pend | flush;
        busy_n  = flush_pend | flush;
        we_n    = 1'b0;
        re_n    = 1'b0;
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        rdv_n   = 1'b0;
        din_n   = fifo_dataIn;
        rdd_n   = rd_data;
        case (state)
            IDLE: begin
                if (flush_pend) begin
                    state_n = FLUSH;
                    re_n    = !fifo_isEmpty;
                end else begin
                    case (grant)
                        SRC_RD: begin
                            state_n = READ;
                            rdd_n   = fifo_dataOut;
                            rdv_n   = 1'b1;
                            re_n    = 1'b1;
                            rr_n    = SRC_W0;
                        end
                        SRC_W0: begin
                            state_n = WRITE;
                            we_n    = 1'b1;
                            din_n   = wr_data0;
                            ack0_n  = 1'b1;
                            rr_n    = SRC_W1;
                        end
                        SRC_W1: begin
                            state_n = WRITE;
                            we_n    = 1'b1;
                            din_n   = wr_data1;
                            ack1_n  = 1'b1;
                            rr_n    = SRC_RD;
                        end
                        default: ;
                    endcase
                end
            end
            WRITE, READ: state_n = IDLE;
            FLUSH: begin
                if (fifo_isEmpty) begin
                    state_n = IDLE;
                    pend_n  = flush;
                    busy_n  = flush;
                end else begin
                    // fifo_count still shows the pre-pop value while a pop is in flight.
                    re_n = fifo_re ? (fifo_count > MEM_SIZE'(1)) : 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= SRC_RD;
            flush_pend  <= 1'b0;
            flush_busy  <= 1'b0;
            fifo_we     <= 1'b0;
            fifo_re     <= 1'b0;
            fifo_dataIn <= 8'h00;
            wr_ack0     <= 1'b0;
            wr_ack1     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= 8'h00;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_n;
            flush_pend  <= pend_n;
            flush_busy  <= busy_n;
            fifo_we     <= we_n;
            fifo_re     <= re_n;
            fifo_dataIn <= din_n;
            wr_ack0     <= ack0_n;
            wr_ack1     <= ack1_n;
            rd_valid    <= rdv_n;
            rd_data     <= rdd_n;
        end
    end

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb/tb_fifo_access_arbiter.sv - directed vector bench for fifo_access_arbiter with behavioural FIFOs
module tb_fifo_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0, fifo_rst_n = 1'b0;

    logic       wr_req0 = 0, wr_req1 = 0, rd_req = 0, flush = 0;
    logic [7:0] wr_data0 = 0, wr_data1 = 0;
    logic       wr_ack0, wr_ack1, rd_valid, flush_busy, fifo_we, fifo_re;
    logic [7:0] rd_data, fifo_dataIn, fifo_dataOut;
    logic [9:0] cnt_a, wp_a, rp_a;
    logic [7:0] mem_a [0:1023];

    logic       b_wr_req0 = 0, b_rd_req = 0;
    logic       b_wr_ack0, b_wr_ack1, b_rd_valid, b_flush_busy, b_fifo_we, b_fifo_re;
    logic [7:0] b_rd_data, b_fifo_dataIn, b_fifo_dataOut;
    logic [9:0] cnt_b, wp_b, rp_b;
    logic [7:0] mem_b [0:1023];

    int checks = 0, errors = 0;

    fifo_access_arbiter dut (
        .clk(clk), .reset(reset),
        .wr_req0(wr_req0), .wr_data0(wr_data0), .wr_ack0(wr_ack0),
        .wr_req1(wr_req1), .wr_data1(wr_data1), .wr_ack1(wr_ack1),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .flush(flush), .flush_busy(flush_busy),
        .fifo_we(fifo_we), .fifo_re(fifo_re), .fifo_dataIn(fifo_dataIn),
        .fifo_dataOut(fifo_dataOut), .fifo_count(cnt_a), .fifo_isEmpty(cnt_a == 10'd0)
    );

    fifo_access_arbiter #(.MEM_SIZE(10), .FILL_LIMIT(4)) dut_b (
        .clk(clk), .reset(reset),
        .wr_req0(b_wr_req0), .wr_data0(8'hA0), .wr_ack0(b_wr_ack0),
        .wr_req1(1'b0), .wr_data1(8'h00), .wr_ack1(b_wr_ack1),
        .rd_req(b_rd_req), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .flush(1'b0), .flush_busy(b_flush_busy),
        .fifo_we(b_fifo_we), .fifo_re(b_fifo_re), .fifo_dataIn(b_fifo_dataIn),
        .fifo_dataOut(b_fifo_dataOut), .fifo_count(cnt_b), .fifo_isEmpty(cnt_b == 10'd0)
    );

    assign fifo_dataOut   = mem_a[rp_a];
    assign b_fifo_dataOut = mem_b[rp_b];

    always @(posedge clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            wp_a <= 0; rp_a <= 0; cnt_a <= 0;
            wp_b <= 0; rp_b <= 0; cnt_b <= 0;
        end else begin
            if (fifo_we) begin mem_a[wp_a] <= fifo_dataIn; wp_a <= wp_a + 1'b1; end
            if (fifo_re) rp_a <= rp_a + 1'b1;
            cnt_a <= cnt_a + 10'(fifo_we) - 10'(fifo_re);
            if (b_fifo_we) begin mem_b[wp_b] <= b_fifo_dataIn; wp_b <= wp_b + 1'b1; end
            if (b_fifo_re) rp_b <= rp_b + 1'b1;
            cnt_b <= cnt_b + 10'(b_fifo_we) - 10'(b_fifo_re);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later, checking the standing invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) begin
            chk("we_re_overlap", {31'd0, fifo_we & fifo_re}, 0);
            chk("one_pulse", 32'(wr_ack0) + 32'(wr_ack1) + 32'(rd_valid) <= 1 ? 1 : 0, 1);
            chk("re_when_empty", {31'd0, fifo_re && cnt_a == 0}, 0);
            chk("b_we_at_limit", {31'd0, b_fifo_we && cnt_b >= 4}, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0; fifo_rst_n = 0;
        tick();
        @(negedge clk);
        reset = 1; fifo_rst_n = 1;
    endtask

    typedef struct {
        logic       rst, r0, r1, rd;
        logic [7:0] d0, d1;
        logic       ack0, ack1, rdv, we, re;
        logic [7:0] rdd, din;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic rst, r0, input logic [7:0] d0, input logic r1, input logic [7:0] d1,
                       input logic rd, ack0, ack1, rdv, input logic [7:0] rdd, input logic we, re,
                       input logic [7:0] din);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.rd = rd;
        v.ack0 = ack0; v.ack1 = ack1; v.rdv = rdv; v.rdd = rdd; v.we = we; v.re = re; v.din = din;
        vecs.push_back(v);
    endtask

    int  n, nre;
    logic got, bad;

    initial begin
        // single write then read
        add(1, 0,8'h00, 0,8'h00, 0,  0,0,0,8'h00, 0,0,8'h00);
        add(0, 1,8'h5A, 0,8'h00, 0,  1,0,0,8'h00, 1,0,8'h5A);
        add(0, 0,8'h5A, 0,8'h00, 0,  0,0,0,8'h00, 0,0,8'h5A);
        add(0, 0,8'h00, 0,8'h00, 1,  0,0,1,8'h5A, 0,1,8'h5A);
        add(0, 0,8'h00, 0,8'h00, 0,  0,0,0,8'h5A, 0,0,8'h5A);
        // full contention from reset: W0, W1, RD, W0, W1, RD
        add(1, 1,8'h11, 1,8'h22, 1,  0,0,0,8'h00, 0,0,8'h00);
        add(0, 1,8'h11, 1,8'h22, 1,  1,0,0,8'h00, 1,0,8'h11);
        add(0, 1,8'h11, 1,8'h22, 1,  0,0,0,8'h00, 0,0,8'h11);
        add(0, 1,8'h11, 1,8'h22, 1,  0,1,0,8'h00, 1,0,8'h22);
        add(0, 1,8'h11, 1,8'h22, 1,  0,0,0,8'h00, 0,0,8'h22);
        add(0, 1,8'h11, 1,8'h22, 1,  0,0,1,8'h11, 0,1,8'h22);
        add(0, 1,8'h11, 1,8'h22, 1,  0,0,0,8'h11, 0,0,8'h22);
        add(0, 1,8'h11, 1,8'h22, 1,  1,0,0,8'h11, 1,0,8'h11);
        add(0, 1,8'h11, 1,8'h22, 1,  0,0,0,8'h11, 0,0,8'h11);
        add(0, 1,8'h11, 1,8'h22, 1,  0,1,0,8'h11, 1,0,8'h22);
        add(0, 1,8'h11, 1,8'h22, 1,  0,0,0,8'h11, 0,0,8'h22);
        add(0, 1,8'h11, 1,8'h22, 1,  0,0,1,8'h22, 0,1,8'h22);
        add(0, 1,8'h11, 1,8'h22, 1,  0,0,0,8'h22, 0,0,8'h22);

        do_reset();

        // limited instance: 4 writes, stall, one pop frees one slot
        #1;
        b_wr_req0 = 1;
        n = 0;
        repeat (20) begin tick(); if (b_wr_ack0) n++; end
        chk("b_acks_to_limit", n, 4);
        chk("b_count_at_limit", cnt_b, 4);
        b_rd_req = 1; got = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (b_rd_valid) begin got = 1; b_rd_req = 0; chk("b_rd_data", b_rd_data, 8'hA0); break; end
        end
        b_rd_req = 0;
        chk("b_pop_seen", got, 1);
        n = 0;
        repeat (20) begin tick(); if (b_wr_ack0) n++; end
        chk("b_acks_after_pop", n, 1);
        chk("b_count_refilled", cnt_b, 4);
        b_wr_req0 = 0;

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = !vecs[i].rst; fifo_rst_n = !vecs[i].rst;
            wr_req0 = vecs[i].r0; wr_data0 = vecs[i].d0;
            wr_req1 = vecs[i].r1; wr_data1 = vecs[i].d1;
            rd_req = vecs[i].rd;
            tick();
            chk($sformatf("vec%0d", i),
                {10'd0, wr_ack0, wr_ack1, rd_valid, rd_data, fifo_we, fifo_re, fifo_dataIn, flush_busy},
                {10'd0, vecs[i].ack0, vecs[i].ack1, vecs[i].rdv, vecs[i].rdd, vecs[i].we, vecs[i].re,
                 vecs[i].din, 1'b0});
        end
        @(negedge clk);
        wr_req0 = 0; wr_req1 = 0; rd_req = 0;

        // read waits on empty, then a single write is delivered within 3 cycles
        do_reset();
        rd_req = 1; bad = 0;
        repeat (10) begin tick(); if (rd_valid || fifo_re) bad = 1; end
        chk("empty_wait_quiet", bad, 0);
        wr_req0 = 1; wr_data0 = 8'h77; got = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (wr_ack0) wr_req0 = 0;
            if (rd_valid) begin got = 1; chk("empty_wait_data", rd_data, 8'h77); break; end
        end
        rd_req = 0; wr_req0 = 0;
        chk("empty_wait_latency", got, 1);

        // load 6, flush during the 7th write, drain 7 with no rd_valid
        do_reset();
        wr_req0 = 1; wr_data0 = 8'h40; n = 0;
        for (int k = 0; k < 40 && n < 7; k++) begin
            tick();
            if (wr_ack0) begin
                n++; wr_data0++;
                if (n == 7) begin flush = 1; wr_req0 = 0; end
            end
        end
        wr_req0 = 0;
        chk("flush_loaded_acks", n, 7);
        tick();
        flush = 0;
        chk("flush_busy_set", flush_busy, 1);
        chk("flush_write_done", cnt_a, 7);
        nre = 0; bad = 0; got = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (fifo_re) nre++;
            if (rd_valid || wr_ack0 || wr_ack1) bad = 1;
            if (!flush_busy) begin got = 1; break; end
        end
        chk("flush_exit", got, 1);
        chk("flush_re_cycles", nre, 7);
        chk("flush_no_valid", bad, 0);
        chk("flush_count_zero", cnt_a, 0);

        // reset in the middle of a READ; afterwards RD wins the first grant
        wr_req0 = 1; wr_data0 = 8'h3C; got = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (wr_ack0) begin got = 1; wr_req0 = 0; break; end
        end
        wr_req0 = 0;
        chk("pre_reset_write", got, 1);
        tick();
        rd_req = 1;
        tick();
        chk("read_started", rd_valid, 1);
        wr_req0 = 1; wr_data0 = 8'h55; wr_req1 = 1; wr_data1 = 8'h66;
        #2 reset = 0;
        #1;
        chk("async_reset_outputs",
            {20'd0, wr_ack0, wr_ack1, rd_valid, fifo_we, fifo_re, flush_busy, 2'b00, rd_data | fifo_dataIn},
            0);
        @(negedge clk);
        reset = 1;
        tick();
        chk("post_reset_rd_first", {wr_ack0, wr_ack1, rd_valid}, 3'b001);
        chk("post_reset_rd_data", rd_data, 8'h3C);
        wr_req0 = 0; wr_req1 = 0; rd_req = 0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
